// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Serial-in / byte-out bundle between tick source, line and consumer
// Revision : 1.0
// ============================================================================
interface uart_rx_if #(
  parameter int NB_DATA = 8
) ();
  logic               i_tick;
  logic               i_rx;
  logic [NB_DATA-1:0] o_data;
  logic               o_rx_done;
  logic               o_frame_err;

  // Receiver side
  modport master (
    input  i_tick,
    input  i_rx,
    output o_data,
    output o_rx_done,
    output o_frame_err
  );

  // Driver / consumer side
  modport slave (
    output i_tick,
    output i_rx,
    input  o_data,
    input  o_rx_done,
    input  o_frame_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 16x-oversampled UART receiver, mid-bit sampling, framing check
// Revision : 1.0
// ============================================================================
module uart_rx #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_rx_if.master     bus
);

  localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [4:0]    c_START_MID = 5'd7;
  localparam logic [4:0]    c_BIT_END   = 5'd15;
  localparam logic [4:0]    c_STOP_END  = 5'(SB_TICK - 1);
  localparam logic [BW-1:0] c_LAST_BIT  = BW'(NB_DATA - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [4:0]         r_tick_cnt;
  logic [BW-1:0]      r_bit_cnt;
  logic [NB_DATA-1:0] r_shift;
  logic [NB_DATA-1:0] r_data;
  logic               r_rx_done;
  logic               r_frame_err;
  logic               r_armed;
  logic               r_rx_meta;
  logic               r_rx_s;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= 5'd0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      r_armed     <= 1'b1;
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
    end else begin
      r_rx_meta   <= bus.i_rx;
      r_rx_s      <= r_rx_meta;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;

      // A line that has been seen high re-enables start detection after a break
      if (r_rx_s) begin
        r_armed <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (!r_rx_s && r_armed) begin
            r_state    <= S_START;
            r_tick_cnt <= 5'd0;
          end
        end

        S_START: begin
          if (bus.i_tick) begin
            if (r_tick_cnt == c_START_MID) begin
              r_tick_cnt <= 5'd0;
              if (!r_rx_s) begin
                r_state   <= S_DATA;
                r_bit_cnt <= '0;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 5'd1;
            end
          end
        end

        S_DATA: begin
          if (bus.i_tick) begin
            if (r_tick_cnt == c_BIT_END) begin
              r_tick_cnt <= 5'd0;
              r_shift    <= {r_rx_s, r_shift[NB_DATA-1:1]};
              if (r_bit_cnt == c_LAST_BIT) begin
                r_state <= S_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 5'd1;
            end
          end
        end

        S_STOP: begin
          if (bus.i_tick) begin
            if (r_tick_cnt == c_STOP_END) begin
              r_tick_cnt <= 5'd0;
              r_state    <= S_IDLE;
              if (r_rx_s) begin
                r_data    <= r_shift;
                r_rx_done <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
                r_armed     <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 5'd1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_data      = r_data;
  assign bus.o_rx_done   = r_rx_done;
  assign bus.o_frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Scoreboard bench for uart_rx (8N1 and 7-bit / two-stop instances)
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic [1:0] phase = 2'd0;
  logic rx1 = 1'b1;
  logic rx2 = 1'b1;
  int   tick_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    bit          err;
    logic [31:0] data;
    int          t0;
    int          lat;
  } ev_t;

  ev_t         q1[$];
  ev_t         q2[$];
  logic [31:0] last_ok1 = 32'd0;
  logic [31:0] last_ok2 = 32'd0;
  bit          prev1 = 1'b0;
  bit          prev2 = 1'b0;

  always #5 clk = ~clk;

  uart_rx_if #(.NB_DATA(8)) bus1 ();
  uart_rx_if #(.NB_DATA(7)) bus2 ();

  assign bus1.i_tick = tick;
  assign bus1.i_rx   = rx1;
  assign bus2.i_tick = tick;
  assign bus2.i_rx   = rx2;

  uart_rx #(.NB_DATA(8), .SB_TICK(16)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
  uart_rx #(.NB_DATA(7), .SB_TICK(32)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

  // Tick strobe one cycle in every four
  always @(negedge clk) begin
    phase = phase + 2'd1;
    tick  = (phase == 2'd0);
  end

  always @(posedge clk) begin
    if (tick) tick_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx1 = v;
    else            rx2 = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input int nb,
                            input int sb, input bit stop_ok);
    ev_t e;
    e.err  = !stop_ok;
    e.data = 32'(d);
    e.t0   = tick_cnt;
    e.lat  = 8 + 16 * nb + sb;
    if (which == 0) q1.push_back(e);
    else            q2.push_back(e);
    set_rx(which, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nb; i++) begin
      set_rx(which, d[i]);
      wait_ticks(16);
    end
    set_rx(which, stop_ok);
    wait_ticks(sb);
  endtask

  task automatic on_output(input int which, input logic done, input logic err,
                           input logic [31:0] data);
    ev_t e;
    bit  empty;
    check($sformatf("exclusive%0d", which), 32'(done && err), 32'd0);
    empty = (which == 0) ? (q1.size() == 0) : (q2.size() == 0);
    if (empty) begin
      check($sformatf("unexpected_event%0d", which), 32'({done, err}), 32'd0);
    end else begin
      e = (which == 0) ? q1.pop_front() : q2.pop_front();
      check($sformatf("kind%0d", which), 32'(err), 32'(e.err));
      check($sformatf("latency%0d", which), 32'(tick_cnt - e.t0), 32'(e.lat));
      if (!e.err) begin
        check($sformatf("data%0d", which), data, e.data);
        if (which == 0) last_ok1 = e.data;
        else            last_ok2 = e.data;
      end else begin
        check($sformatf("data_hold%0d", which), data, (which == 0) ? last_ok1 : last_ok2);
      end
    end
  endtask

  always @(negedge clk) begin
    if (prev1) check("pulse_width0", 32'({bus1.o_rx_done, bus1.o_frame_err}), 32'd0);
    if (prev2) check("pulse_width1", 32'({bus2.o_rx_done, bus2.o_frame_err}), 32'd0);
    prev1 = bus1.o_rx_done || bus1.o_frame_err;
    prev2 = bus2.o_rx_done || bus2.o_frame_err;
    if (prev1) on_output(0, bus1.o_rx_done, bus1.o_frame_err, 32'(bus1.o_data));
    if (prev2) on_output(1, bus2.o_rx_done, bus2.o_frame_err, 32'(bus2.o_data));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data0", 32'(bus1.o_data), 32'd0);
    check("reset_done0", 32'(bus1.o_rx_done), 32'd0);
    check("reset_err0", 32'(bus1.o_frame_err), 32'd0);
    check("reset_data1", 32'(bus2.o_data), 32'd0);
    rst = 1'b0;
    wait_ticks(4);

    // Single frame
    send_frame(0, 8'h55, 8, 16, 1'b1);
    wait_ticks(16);
    check("q_after_55", 32'(q1.size()), 32'd0);

    // Back-to-back, no idle between frames
    send_frame(0, 8'hA3, 8, 16, 1'b1);
    send_frame(0, 8'h0F, 8, 16, 1'b1);
    wait_ticks(16);
    check("q_after_b2b", 32'(q1.size()), 32'd0);

    // Short low glitch must be rejected at the start-bit midpoint
    rx1 = 1'b0;
    wait_ticks(5);
    rx1 = 1'b1;
    wait_ticks(40);
    check("glitch_data_hold", 32'(bus1.o_data), 32'h0F);

    // Framing error followed by a break, then a good frame
    send_frame(0, 8'h3C, 8, 16, 1'b0);
    wait_ticks(3 * 160);
    check("q_after_break", 32'(q1.size()), 32'd0);
    rx1 = 1'b1;
    wait_ticks(32);
    send_frame(0, 8'h81, 8, 16, 1'b1);
    wait_ticks(16);
    check("q_after_81", 32'(q1.size()), 32'd0);

    // Reset during data bit 4 of 0xFF
    rx1 = 1'b0;
    wait_ticks(16);
    rx1 = 1'b1;
    wait_ticks(16 * 4 + 8);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midreset_data", 32'(bus1.o_data), 32'd0);
    check("midreset_done", 32'(bus1.o_rx_done), 32'd0);
    check("midreset_err", 32'(bus1.o_frame_err), 32'd0);
    rst = 1'b0;
    last_ok1 = 32'd0;
    wait_ticks(64);
    check("after_reset_data", 32'(bus1.o_data), 32'd0);
    send_frame(0, 8'h12, 8, 16, 1'b1);
    wait_ticks(16);

    // 7 data bits, two stop bits
    send_frame(1, 8'h5A, 7, 32, 1'b1);
    wait_ticks(16);

    for (int i = 0; i < 2000 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    check("drain_q0", 32'(q1.size()), 32'd0);
    check("drain_q1", 32'(q2.size()), 32'd0);
    check("final_data0", 32'(bus1.o_data), 32'h12);
    check("final_data1", 32'(bus2.o_data), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
